// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: FSM state
// encoding, default store placement and the fault/trap instruction word.
package imem_responder_pkg;

  // Fetch handshake FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FETCH = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // ebreak encoding, also matched by the sim trap logic
  localparam logic [31:0] EBREAK_INSN     = 32'h0010_0073;

  localparam logic [31:0] IMEM_BASE_ADDR  = 32'h8000_0000;
  localparam logic [31:0] IMEM_FAULT_WORD = EBREAK_INSN;

endpackage

// File: rtl/imem_store.sv
// Word-addressed instruction store: DEPTH x 32, synchronous write,
// synchronous registered read. A read and a write to the same index on
// the same edge return the old word (read-before-write).
// Ports:
//   clk, rst         clock, async active-low reset (read register only)
//   wr_en_i/idx/data write port
//   rd_en_i/idx      read request, data appears on rd_data_o next cycle
//   rd_data_o        registered read data, held until the next read
module imem_store #(
  parameter int unsigned DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
  input  logic [31:0]              wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output logic [31:0]              rd_data_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_data_q;

  // Array write; contents deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Read register; NBA ordering gives read-before-write on a shared index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= 32'h0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder for the CPU fetch handshake. Accepts a fetch
// address when ready is seen in IDLE, waits lat_cfg cycles, reads the store
// and presents the word (or FAULT_WORD with access_fault) until accepted.
// Ports:
//   clk, rst                         clock, async active-low reset
//   imem_raddr, imem_rdata_ready     fetch request in
//   imem_rdata_valid/bits            response out
//   access_fault                     response is a fault (valid only)
//   lat_cfg                          extra wait cycles per request
//   load_en/addr/data                store write port
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = IMEM_BASE_ADDR,
  parameter int unsigned DEPTH      = 4096,
  parameter logic [31:0] FAULT_WORD = IMEM_FAULT_WORD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              imem_raddr,
  input  logic                     imem_rdata_ready,
  output logic                     imem_rdata_valid,
  output logic [31:0]              imem_rdata_bits,
  output logic                     access_fault,
  input  logic [3:0]               lat_cfg,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic [31:0] word_off_c;
  logic        range_fault_c;
  logic        store_rd_en_c;
  logic [31:0] store_rdata;

  // Word offset is only meaningful when req_addr >= BASE_ADDR; the explicit
  // lower-bound test keeps the check from wrapping at either end.
  assign word_off_c    = (req_addr_q - BASE_ADDR) >> 2;
  assign range_fault_c = (req_addr_q[1:0] != 2'b00) ||
                         (req_addr_q < BASE_ADDR)   ||
                         (word_off_c >= 32'(DEPTH));

  imem_store #(.DEPTH(DEPTH)) u_store (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (load_en),
    .wr_idx_i  (load_addr),
    .wr_data_i (load_data),
    .rd_en_i   (store_rd_en_c),
    .rd_idx_i  (word_off_c[AW-1:0]),
    .rd_data_o (store_rdata)
  );

  // State and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      req_addr_q <= 32'h0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_addr_q <= req_addr_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

  // Next-state and response control
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_addr_d    = req_addr_q;
    valid_d       = valid_q;
    fault_d       = fault_q;
    store_rd_en_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (imem_rdata_ready) begin
          req_addr_d = imem_raddr;
          cnt_d      = lat_cfg;
          state_d    = (lat_cfg == 4'd0) ? ST_FETCH : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = 4'(cnt_q - 4'd1);
        if (cnt_q == 4'd1) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        store_rd_en_c = 1'b1;
        fault_d       = range_fault_c;
        valid_d       = 1'b1;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        if (imem_rdata_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Both mux inputs are registers, so bits stay stable while RESP holds
  assign imem_rdata_valid = valid_q;
  assign access_fault     = fault_q;
  assign imem_rdata_bits  = fault_q ? FAULT_WORD : store_rdata;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] imem_raddr;
  logic        imem_rdata_ready;
  logic        imem_rdata_valid;
  logic [31:0] imem_rdata_bits;
  logic        access_fault;
  logic [3:0]  lat_cfg;
  logic        load_en;
  logic [11:0] load_addr;
  logic [31:0] load_data;

  int errors = 0;
  int checks = 0;

  imem_responder dut (
    .clk              (clk),
    .rst              (rst),
    .imem_raddr       (imem_raddr),
    .imem_rdata_ready (imem_rdata_ready),
    .imem_rdata_valid (imem_rdata_valid),
    .imem_rdata_bits  (imem_rdata_bits),
    .access_fault     (access_fault),
    .lat_cfg          (lat_cfg),
    .load_en          (load_en),
    .load_addr        (load_addr),
    .load_data        (load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [11:0] idx, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = idx;
    load_data = data;
    step();
    load_en   = 1'b0;
  endtask

  // One request with ready held high until the handshake
  task automatic do_req(input string tag, input logic [31:0] addr, input logic [3:0] lat,
                        input logic [31:0] exp_bits, input logic exp_fault);
    int n;
    n = 0;
    imem_raddr       = addr;
    lat_cfg          = lat;
    imem_rdata_ready = 1'b1;
    do begin
      step();
      n++;
      if (n == 1) imem_raddr = ~addr;
    end while (!imem_rdata_valid && n < 40);
    chk({tag, "_latency"}, 32'(n), 32'(lat) + 32'd2);
    chk({tag, "_bits"}, imem_rdata_bits, exp_bits);
    chk({tag, "_fault"}, 32'(access_fault), 32'(exp_fault));
    step();
    imem_rdata_ready = 1'b0;
    chk({tag, "_valid_fall"}, 32'(imem_rdata_valid), 32'd0);
  endtask

  initial begin
    rst              = 1'b0;
    imem_raddr       = 32'h0;
    imem_rdata_ready = 1'b0;
    lat_cfg          = 4'd0;
    load_en          = 1'b0;
    load_addr        = 12'd0;
    load_data        = 32'h0;

    // Reset state
    #1;
    chk("rst_valid", 32'(imem_rdata_valid), 32'd0);
    chk("rst_bits", imem_rdata_bits, 32'h0);
    chk("rst_fault", 32'(access_fault), 32'd0);
    #11 rst = 1'b1;
    step();

    // Preload store
    load(12'd0,    32'h0000_0413);
    load(12'd1,    32'h00A0_0093);
    load(12'd2,    32'h1111_1111);
    load(12'd4095, 32'hCAFE_F00D);
    step();
    chk("idle_no_valid", 32'(imem_rdata_valid), 32'd0);

    // Basic fetch and programmed latency
    do_req("basic", 32'h8000_0000, 4'd0, 32'h0000_0413, 1'b0);
    do_req("lat5",  32'h8000_0004, 4'd5, 32'h00A0_0093, 1'b0);
    do_req("last",  32'h8000_3FFC, 4'd0, 32'hCAFE_F00D, 1'b0);

    // Faults
    do_req("f_mis",  32'h8000_0002, 4'd0, 32'h0010_0073, 1'b1);
    do_req("f_low",  32'h7FFF_FFFC, 4'd0, 32'h0010_0073, 1'b1);
    do_req("f_high", 32'h8000_4000, 4'd1, 32'h0010_0073, 1'b1);
    do_req("f_top",  32'hFFFF_FFFC, 4'd0, 32'h0010_0073, 1'b1);

    // Ready backpressure in RESP
    imem_raddr       = 32'h8000_0000;
    lat_cfg          = 4'd1;
    imem_rdata_ready = 1'b1;
    step();
    imem_rdata_ready = 1'b0;
    imem_raddr       = 32'h8000_0004;
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(imem_rdata_valid), 32'd1);
      chk("bp_bits", imem_rdata_bits, 32'h0000_0413);
      step();
    end
    imem_rdata_ready = 1'b1;
    chk("bp_valid_hs", 32'(imem_rdata_valid), 32'd1);
    step();
    imem_rdata_ready = 1'b0;
    chk("bp_idle", 32'(imem_rdata_valid), 32'd0);
    step();
    step();
    chk("bp_no_reaccept", 32'(imem_rdata_valid), 32'd0);

    // Load during WAIT returns the new word
    imem_raddr       = 32'h8000_0008;
    lat_cfg          = 4'd3;
    imem_rdata_ready = 1'b1;
    step();
    imem_rdata_ready = 1'b0;
    load(12'd2, 32'h2222_2222);
    step();
    step();
    step();
    chk("ld_wait_valid", 32'(imem_rdata_valid), 32'd1);
    chk("ld_wait_bits", imem_rdata_bits, 32'h2222_2222);
    imem_rdata_ready = 1'b1;
    step();
    imem_rdata_ready = 1'b0;

    // Load in the FETCH cycle returns the old word
    load(12'd2, 32'h1111_1111);
    imem_rdata_ready = 1'b1;
    step();
    imem_rdata_ready = 1'b0;
    step();
    step();
    step();
    chk("ld_fetch_pre", 32'(imem_rdata_valid), 32'd0);
    load(12'd2, 32'h3333_3333);
    chk("ld_fetch_valid", 32'(imem_rdata_valid), 32'd1);
    chk("ld_fetch_bits", imem_rdata_bits, 32'h1111_1111);
    imem_rdata_ready = 1'b1;
    step();
    imem_rdata_ready = 1'b0;
    do_req("ld_after", 32'h8000_0008, 4'd0, 32'h3333_3333, 1'b0);

    // Reset during WAIT
    imem_raddr       = 32'h8000_0004;
    lat_cfg          = 4'd8;
    imem_rdata_ready = 1'b1;
    step();
    imem_rdata_ready = 1'b0;
    step();
    #3 rst = 1'b0;
    #1;
    chk("rw_valid", 32'(imem_rdata_valid), 32'd0);
    chk("rw_bits", imem_rdata_bits, 32'h0);
    chk("rw_fault", 32'(access_fault), 32'd0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("rw_no_stale", 32'(imem_rdata_valid), 32'd0);
    do_req("rw_next", 32'h8000_0004, 4'd2, 32'h00A0_0093, 1'b0);

    // Reset during RESP
    imem_raddr       = 32'h8000_0008;
    lat_cfg          = 4'd0;
    imem_rdata_ready = 1'b1;
    step();
    imem_rdata_ready = 1'b0;
    step();
    chk("rr_valid_pre", 32'(imem_rdata_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rr_valid", 32'(imem_rdata_valid), 32'd0);
    chk("rr_bits", imem_rdata_bits, 32'h0);
    step();
    rst = 1'b1;
    step();
    step();
    chk("rr_no_stale", 32'(imem_rdata_valid), 32'd0);
    do_req("rr_next", 32'h8000_0000, 4'd1, 32'h0000_0413, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
